seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Parametrised shift-add sequential multiplier: WIDTH x WIDTH -> 2*WIDTH product.
//  Operates in unsigned or two's-complement signed mode, selected per operation.
//  Uses a start/busy/done handshake. Datapath unit of the 8-bit ALU, reusable at any width.
//  Holds the product stable until the next operation completes.
// PARAMETERS
//  WIDTH    8   operand width in bits (>=2); product is 2*WIDTH bits
//  CNT_W    $clog2(WIDTH)+1   iteration-counter width (derived, not overridden)
// PORTS
//  clk          in   1         rising-edge clock
//  rst_n        in   1         asynchronous reset, active low
//  start        in   1         request; sampled only in IDLE
//  signed_mode  in   1         1 = a,b,op two's complement; 0 = unsigned
//  a            in   WIDTH     multiplicand, sampled with start
//  b            in   WIDTH     multiplier, sampled with start
//  op           out  2*WIDTH   product, registered
//  busy         out  1         high in RUN and FIX
//  done         out  1         one-cycle pulse, op valid from this cycle on
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, op=0, busy=0, done=0, counter=0, internal regs=0.
//  States: IDLE -> RUN -> FIX -> IDLE.
//  IDLE: start=1 at edge E0 captures operands.
//   - Captures |a| and |b| when signed_mode=1, else raw values.
//   - neg_flag = signed_mode & (a[MSB]^b[MSB]).
//   - Clears the accumulator, counter=0; goes to RUN.
//  RUN: one radix-2 step per edge.
//   - If multiplier LSB=1, add multiplicand to upper half of accumulator (WIDTH+1-bit add).
//   - Shift {carry,acc} right by 1; counter++.
//   - After the WIDTH-th step (edge E0+WIDTH), go to FIX.
//  FIX (edge E0+WIDTH+1): op <= neg_flag ? -acc : acc (2*WIDTH-bit two's complement);
//   done=1 for that cycle; go to IDLE.
//  Latency: done first visible WIDTH+1 cycles after the start edge.
//   op is unchanged between operations.
//  Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1): treat as unsigned WIDTH bits, no overflow.
//   Signed product always fits in 2*WIDTH bits.
//  start while busy=1: ignored; no queueing, operands not resampled.
//  start in the done cycle: accepted (state is IDLE). Back-to-back period is WIDTH+1 cycles.
//  a, b, signed_mode changes after E0: no effect on the operation in flight.
//  Zero operand: still WIDTH+1 cycles, no early termination; result 0, never -0 issues.
//  rst_n asserted mid-operation: immediate abort to reset values; no done pulse.
//  busy = (state!=IDLE); done never coincides with busy=1.
// STRUCTURE
//  Shared include mult_defs.vh:
//   - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIX=2'd2.
//   - Reused by future divider/ALU sequencer blocks.
//  One sub-module: twos_abs #(W) (in: x, en; out: en&x[MSB] ? -x : x).
//   - Instantiated for a, b (W=WIDTH) and for the FIX negate (W=2*WIDTH, en=neg_flag).
//  The rest is a single always block for FSM and datapath, plus a counter.
// TESTING
//  1. WIDTH=8, unsigned, a=0x83, b=0x82, pulse start.
//     -> done exactly 9 cycles later, op=0x4286, busy high 9 cycles.
//  2. WIDTH=8, signed, a=0x83(-125), b=0x82(-126) -> op=0x3D86.
//     Then a=0x80, b=0x7F -> op=0xC080.
//  3. Corner values, WIDTH=8.
//     -> unsigned 0xFF*0xFF=0xFE01; signed 0x80*0x80=0x4000; a=0 -> op=0, latency still 9.
//  4. start held high through RUN with changing a/b.
//     -> result of first operands only; next op starts on the done cycle; done every 9 cycles.
//  5. rst_n low mid-RUN at cycle 4.
//     -> op=0, busy=0, done=0 asynchronously; no done pulse. After release, a fresh op works.
//  6. WIDTH=16 instance, signed, a=0xFFFF(-1), b=0x8000.
//     -> op=0x00008000 after 17 cycles. Random self-check vs a*b, 1000 vectors.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier_pkg
// Brief   : Shared state encoding for the shift-add multiplier sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package seq_multiplier_pkg;

    // Encodings are shared with the divider/ALU sequencer blocks.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage : seq_multiplier_pkg
`default_nettype wire

// File: rtl/seq_multiplier_twos_abs.sv
`default_nettype none
// ============================================================================
// Module  : twos_abs
// Brief   : Conditional two's-complement negate (absolute value / sign apply).
// Revision: 1.0 - initial release
// ============================================================================
module twos_abs #(
    parameter int W          = 8,
    parameter bit SIGN_GATED = 1'b1
) (
    input  logic [W-1:0] x,
    input  logic         en,
    output logic [W-1:0] y
);

    logic w_neg;

    // SIGN_GATED=1 gives |x|; SIGN_GATED=0 negates whenever en is set,
    // which applies a sign to a magnitude whose MSB is always clear.
    assign w_neg = SIGN_GATED ? (en & x[W-1]) : en;
    assign y     = w_neg ? (~x + W'(1)) : x;

endmodule : twos_abs
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier
// Brief   : Radix-2 shift-add WIDTH x WIDTH multiplier, signed/unsigned per op.
// Revision: 1.0 - initial release
// ============================================================================
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   op,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t                 r_state;
    state_t                 w_next;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_neg;

    logic [WIDTH-1:0]       w_abs_a;
    logic [WIDTH-1:0]       w_abs_b;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_fix;
    logic                   w_last;

    twos_abs #(.W(WIDTH), .SIGN_GATED(1'b1)) u_abs_a (
        .x  (a),
        .en (signed_mode),
        .y  (w_abs_a)
    );

    twos_abs #(.W(WIDTH), .SIGN_GATED(1'b1)) u_abs_b (
        .x  (b),
        .en (signed_mode),
        .y  (w_abs_b)
    );

    twos_abs #(.W(2*WIDTH), .SIGN_GATED(1'b0)) u_fix (
        .x  (r_acc),
        .en (r_neg),
        .y  (w_fix)
    );

    // Carry out of the upper-half add becomes the new accumulator MSB on shift.
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                  + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_last = (r_cnt == CNT_W'(WIDTH-1));
    assign busy   = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            op       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                ST_FIX: begin
                    op   <= w_fix;
                    done <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule : seq_multiplier
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_multiplier
// Brief   : Self-checking bench for seq_multiplier at WIDTH=8 and WIDTH=16.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] op8;
    logic        busy8, done8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] op16;
    logic        busy16, done16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .op(op8), .busy(busy8), .done(done8)
    );

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .op(op16), .busy(busy16), .done(done16)
    );

    // Product of w-bit operands as integers, truncated to 2w bits.
    function automatic longint refmul(input longint x, input longint y, input int w, input bit sm);
        longint one = 1;
        if (sm && x[w-1]) x = x - (one << w);
        if (sm && y[w-1]) y = y - (one << w);
        return (x * y) & ((one << (2*w)) - 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Behavioural model: an accepted op completes WIDTH+1 edges later.
    int          m8_rem = 0, m16_rem = 0;
    logic [15:0] m8_prod = '0, m8_op = '0;
    logic [31:0] m16_prod = '0, m16_op = '0;
    logic        m8_done = 1'b0, m16_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_rem <= 0;  m8_op <= '0;  m8_done <= 1'b0;
            m16_rem <= 0; m16_op <= '0; m16_done <= 1'b0;
        end else begin
            m8_done  <= 1'b0;
            m16_done <= 1'b0;
            if (m8_rem == 0) begin
                if (start8) begin
                    m8_prod <= 16'(refmul(longint'(a8), longint'(b8), 8, sm8));
                    m8_rem  <= 9;
                end
            end else begin
                m8_rem <= m8_rem - 1;
                if (m8_rem == 1) begin
                    m8_op   <= m8_prod;
                    m8_done <= 1'b1;
                end
            end
            if (m16_rem == 0) begin
                if (start16) begin
                    m16_prod <= 32'(refmul(longint'(a16), longint'(b16), 16, sm16));
                    m16_rem  <= 17;
                end
            end else begin
                m16_rem <= m16_rem - 1;
                if (m16_rem == 1) begin
                    m16_op   <= m16_prod;
                    m16_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy8",  64'(busy8),  64'(m8_rem != 0));
            chk("done8",  64'(done8),  64'(m8_done));
            chk("op8",    64'(op8),    64'(m8_op));
            chk("busy16", 64'(busy16), 64'(m16_rem != 0));
            chk("done16", 64'(done16), 64'(m16_done));
            chk("op16",   64'(op16),   64'(m16_op));
        end
    end

    task automatic run8(input string nm, input bit sm, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] expv);
        int lat = 0;
        int bc  = 0;
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0;
        if (busy8) bc++;
        for (int i = 1; i <= 40; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            @(negedge clk);
            lat = i;
            if (done8) break;
            if (busy8) bc++;
        end
        chk({nm, "_lat"},  64'(lat), 64'd9);
        chk({nm, "_busy"}, 64'(bc),  64'd9);
        chk({nm, "_op"},   64'(op8), 64'(expv));
    endtask

    task automatic run16(input string nm, input bit sm, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] expv);
        int lat = 0;
        @(negedge clk);
        start16 = 1'b1; sm16 = sm; a16 = x; b16 = y;
        @(negedge clk);
        start16 = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
            @(negedge clk);
            lat = i;
            if (done16) break;
        end
        chk({nm, "_lat"}, 64'(lat),  64'd17);
        chk({nm, "_op"},  64'(op16), 64'(expv));
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic [15:0] rc, rd;
        bit          rs;
        int          n;

        repeat (3) @(negedge clk);
        chk("rst_op8",   64'(op8),   64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        chk("rst_op16",  64'(op16),  64'd0);
        #1 rst_n = 1'b1;

        run8("t1_u", 1'b0, 8'h83, 8'h82, 16'h4286);
        chk("t1_model", 64'(m8_op), 64'h4286);
        run8("t2_s", 1'b1, 8'h83, 8'h82, 16'h3D86);
        chk("t2_model", 64'(m8_op), 64'h3D86);
        run8("t2_s2", 1'b1, 8'h80, 8'h7F, 16'hC080);
        run8("t3_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run8("t3_80", 1'b1, 8'h80, 8'h80, 16'h4000);
        run8("t3_z",  1'b1, 8'h00, 8'h5A, 16'h0000);
        run8("t3_zn", 1'b1, 8'hC3, 8'h00, 16'h0000);

        // start held high with operands changing every cycle
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            if (done8) begin
                n++;
                if (n == 1) chk("t4_first", 64'(op8), 64'h03A8);
            end
        end
        chk("t4_ndone", 64'(n >= 3), 64'd1);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'hA5; b8 = 8'h3C;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_op",   64'(op8),   64'd0);
        chk("t5_busy", 64'(busy8), 64'd0);
        chk("t5_done", 64'(done8), 64'd0);
        n = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done8) n++;
        end
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done8) n++;
        end
        chk("t5_nodone", 64'(n), 64'd0);
        run8("t5_after", 1'b0, 8'h0F, 8'h11, 16'h00FF);

        run16("t6_s", 1'b1, 16'hFFFF, 16'h8000, 32'h00008000);
        chk("t6_model", 64'(m16_op), 64'h00008000);
        run16("t6_u", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            run8("r8", rs, ra, rb, 16'(refmul(longint'(ra), longint'(rb), 8, rs)));
        end
        for (int i = 0; i < 1000; i++) begin
            rc = 16'($urandom); rd = 16'($urandom); rs = 1'($urandom);
            run16("r16", rs, rc, rd, 32'(refmul(longint'(rc), longint'(rd), 16, rs)));
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_multiplier
`default_nettype wire
